// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM for the multicycle RV32I core. It sequences the shared
// datapath through fetch, decode and execute states, and it drives every mux
// select and write enable. The outputs are Moore-decoded from the state
// register. mem_ready (in FETCH and MEMWRITE) and zero (in BRANCH) qualify
// some of them.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode, funct3, funct7b5 : fields of the instruction register
//   zero                     : ALU zero flag
//   mem_ready                : memory completes the current access
//   pc_write, adr_src, mem_write, ir_write, reg_write : datapath enables
//   result_src, alu_src_a, alu_src_b, alu_control, imm_src : datapath selects
//   retire                   : one-cycle pulse per completed instruction
//   illegal                  : high while parked in TRAP
//   state                    : current state, for debug
module multicycle_controller #(
    parameter int STATE_W         = 4,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               retire,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALU function decode for EXECR/EXECI. Only R-type (opcode[5] = 1) can subtract.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic op5);
        logic [2:0] op_s;
        case (f3)
            3'b000:  op_s = (f7b5 && op5) ? ALU_SUB : ALU_ADD;
            3'b010:  op_s = ALU_SLT;
            3'b110:  op_s = ALU_OR;
            3'b111:  op_s = ALU_AND;
            default: op_s = ALU_ADD;
        endcase
        return op_s;
    endfunction

    state_t state_q, state_d;

    logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, imm_src_s;
    logic [2:0] alu_control_s;
    logic       retire_s, illegal_s;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d       = state_q;
        pc_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = ALU_ADD;
        retire_s      = 1'b0;
        illegal_s     = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut as the branch/jal target.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            retire_s = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b00;
                alu_control_s = alu_decode(funct3, funct7b5, opcode[5]);
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_decode(funct3, funct7b5, opcode[5]);
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = ALU_SUB;
                case (funct3)
                    3'b000:  pc_write_s = zero;
                    3'b001:  pc_write_s = ~zero;
                    default: pc_write_s = 1'b0;
                endcase
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // OldPC + 4 goes to ALUOut as the link value; PC takes the target.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                illegal_s = 1'b1;
                state_d   = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The immediate format depends only on the opcode and is valid in every state.
    always_comb begin
        case (opcode)
            OP_LW, OP_ITYPE: imm_src_s = 2'b00;
            OP_SW:           imm_src_s = 2'b01;
            OP_BRANCH:       imm_src_s = 2'b10;
            OP_JAL:          imm_src_s = 2'b11;
            default:         imm_src_s = 2'b00;
        endcase
    end

    // While reset is held, every enable and select is forced low without waiting for a clock.
    always_comb begin
        if (!reset) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_control = 3'b000;
            imm_src     = 2'b00;
            retire      = 1'b0;
            illegal     = 1'b0;
        end else begin
            pc_write    = pc_write_s;
            adr_src     = adr_src_s;
            mem_write   = mem_write_s;
            ir_write    = ir_write_s;
            reg_write   = reg_write_s;
            result_src  = result_src_s;
            alu_src_a   = alu_src_a_s;
            alu_src_b   = alu_src_b_s;
            alu_control = alu_control_s;
            imm_src     = imm_src_s;
            retire      = retire_s;
            illegal     = illegal_s;
        end
    end

    assign state = STATE_W'(state_q);

endmodule
